// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, in-order instruction-memory reads, prefetch FIFO and valid/ready hand-off to the core.
// Optional FETCH_STALL_CNT_EN adds a saturating core-starvation counter on stall_cnt.
module instr_fetch_unit #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [15:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
  localparam int OW = $clog2(MAX_OUTST + 1);
  logic [ADDR_W-1:0] pc;
  logic [15:0] f_data [DEPTH];
  logic [ADDR_W-1:0] f_pc [DEPTH];
  logic [AW-1:0] f_rd, f_wr;
  logic [CW-1:0] f_cnt;
  logic [ADDR_W-1:0] t_pc [MAX_OUTST];
  logic [TW-1:0] t_rd, t_wr;
  logic [OW-1:0] outst, drop;
  logic grant, resp, push, pop;
  function automatic logic [TW-1:0] t_inc(input logic [TW-1:0] p);
    return (int'(p) == MAX_OUTST - 1) ? '0 : p + 1'b1;
  endfunction
  // Reads in flight reserve FIFO slots, so a returning word always has room.
  always_comb begin
    imem_req = !reset && !redirect && (int'(outst) + int'(f_cnt) < DEPTH) && (int'(outst) < MAX_OUTST);
    imem_addr = pc;
    grant = imem_req && imem_gnt;
    resp = imem_rvalid && outst != '0;
    push = resp && drop == '0;
    instr_valid = f_cnt != '0;
    pop = instr_valid && instr_ready;
    instr = instr_valid ? f_data[f_rd] : '0;
    instr_pc = instr_valid ? f_pc[f_rd] : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
      f_rd <= '0;
      f_wr <= '0;
      f_cnt <= '0;
      t_rd <= '0;
      t_wr <= '0;
      outst <= '0;
      drop <= '0;
    end else if (redirect) begin
      pc <= redirect_pc;
      f_rd <= '0;
      f_wr <= '0;
      f_cnt <= '0;
      t_rd <= '0;
      t_wr <= '0;
      outst <= outst - OW'(resp);
      drop <= outst - OW'(resp);
    end else begin
      if (grant) pc <= pc + 1'b1;
      if (grant) t_wr <= t_inc(t_wr);
      if (push) t_rd <= t_inc(t_rd);
      if (push) f_wr <= f_wr + 1'b1;
      if (pop) f_rd <= f_rd + 1'b1;
      f_cnt <= f_cnt + CW'(push) - CW'(pop);
      outst <= outst + OW'(grant) - OW'(resp);
      drop <= drop - OW'(resp && drop != '0);
    end
  end
  always_ff @(posedge clk) begin
    if (grant) t_pc[t_wr] <= pc;
    if (push) f_data[f_wr] <= imem_rdata;
    if (push) f_pc[f_wr] <= t_pc[t_rd];
  end
`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt <= '0;
    else if (instr_ready && !instr_valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized memory/core stimulus checked every cycle against a queue-based fetch model.
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;
  localparam int MAX_OUTST = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;
  logic clk = 0, reset = 0, imem_req, imem_gnt = 0, imem_rvalid = 0, redirect = 0;
  logic instr_valid, instr_ready = 0;
  logic [15:0] imem_addr, imem_rdata = 0, redirect_pc = 0, instr, instr_pc;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt, s_stall;
`endif
  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH), .ADDR_W(16), .RESET_PC(RESET_PC), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {int due; logic [15:0] addr;} mreq_t;
  typedef struct {logic [15:0] pc; bit stale;} out_t;
  typedef struct {logic [15:0] w; logic [15:0] pc;} fe_t;
  typedef struct {logic [15:0] w; logic [15:0] pc; int cyc;} log_t;
  mreq_t mem_q[$];
  out_t q_out[$];
  fe_t q_f[$];
  log_t dlog[$];
  logic [15:0] m_pc = RESET_PC, force_pc = 0, s_addr;
  bit s_req, s_valid, want_reset = 0, force_rd = 0;
  int m_stall = 0, cyc = 0, vectors = 0, errors = 0;
  int lat_lo = 1, lat_hi = 1, gmode = 0, rmode = 0, rd_pct = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'd0: return 16'h0050;
      16'd1: return 16'h2041;
      16'd2: return 16'h4041;
      16'd3: return 16'h6050;
      default: return (a * 16'd7) ^ 16'hC3A5;
    endcase
  endfunction

  function automatic bit m_req();
    return !reset && !redirect && (q_out.size() + q_f.size() < DEPTH) && (q_out.size() < MAX_OUTST);
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    s_req = imem_req;
    s_addr = imem_addr;
    s_valid = instr_valid;
`ifdef FETCH_STALL_CNT_EN
    s_stall = stall_cnt;
    chk("stall_cnt", stall_cnt, 32'(m_stall));
`endif
    if (reset) begin
      chk("rst_imem_req", imem_req, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_instr_pc", instr_pc, 0);
      return;
    end
    chk("imem_req", imem_req, m_req());
    if (m_req()) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", instr_valid, q_f.size() != 0);
    if (q_f.size() != 0) begin
      chk("instr", instr, q_f[0].w);
      chk("instr_pc", instr_pc, q_f[0].pc);
    end
  endtask

  // Outstanding reads are tracked by address; a redirect marks every one still in flight as stale.
  task automatic model_update();
    out_t r;
    bit got = imem_rvalid && q_out.size() != 0;
    bit req = m_req();
    bit pop = q_f.size() != 0 && instr_ready;
    if (instr_ready && q_f.size() == 0 && m_stall < 65535) m_stall++;
    if (got) r = q_out.pop_front();
    if (redirect) begin
      foreach (q_out[i]) q_out[i].stale = 1;
      q_f.delete();
      m_pc = redirect_pc;
    end else begin
      if (pop) begin
        dlog.push_back('{q_f[0].w, q_f[0].pc, cyc});
        void'(q_f.pop_front());
      end
      if (got && !r.stale) q_f.push_back('{imem_rdata, r.pc});
      if (req && imem_gnt) begin
        q_out.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 16'd1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    reset = want_reset;
    if (reset) begin
      q_out.delete();
      q_f.delete();
      m_pc = RESET_PC;
      m_stall = 0;
    end
    imem_rvalid = 0;
    imem_rdata = 0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1;
      imem_rdata = mem_word(mem_q[0].addr);
    end
    imem_gnt = (gmode == 2) ? ($urandom_range(0, 3) != 0) : (gmode == 1);
    instr_ready = (rmode == 2) ? ($urandom_range(0, 2) != 0) : (rmode == 1);
    redirect = 0;
    if (!reset && force_rd) begin
      redirect = 1;
      redirect_pc = force_pc;
      force_rd = 0;
    end else if (!reset && $urandom_range(0, 99) < rd_pct) begin
      redirect = 1;
      redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
    end
    #1 compare_all();
    @(posedge clk);
    if (!reset) model_update();
    if (imem_rvalid) void'(mem_q.pop_front());
    if (s_req && imem_gnt) mem_q.push_back('{cyc + int'($urandom_range(lat_lo, lat_hi)), s_addr});
    cyc++;
  endtask

  task automatic timeout(input string n);
    vectors++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", n, cyc);
  endtask

  initial begin
    int rel, n;
    logic [15:0] wd [4] = '{16'h0050, 16'h2041, 16'h4041, 16'h6050};
    want_reset = 1;
    repeat (2) step();
    // Streaming from reset, 1-cycle memory
    want_reset = 0;
    gmode = 1;
    rmode = 1;
    dlog.delete();
    rel = cyc;
    repeat (12) step();
    for (int i = 0; i < 4; i++) begin
      chk("first_word", dlog[i].w, wd[i]);
      chk("first_pc", dlog[i].pc, 32'(i));
      chk("first_cycle", 32'(dlog[i].cyc - rel), 32'(2 + i));
    end
    // Core stalls, FIFO fills, then drains back-to-back
    rmode = 0;
    repeat (10) step();
    chk("full_req", s_req, 0);
    chk("full_valid", s_valid, 1);
    dlog.delete();
    rel = cyc;
    rmode = 1;
    repeat (10) step();
    for (int i = 0; i < 8; i++) begin
      chk("drain_cycle", 32'(dlog[i].cyc - rel), 32'(i));
      chk("drain_pc", dlog[i].pc, dlog[0].pc + 16'(i));
    end
    // Redirect with three reads in flight
    lat_lo = 3;
    lat_hi = 3;
    n = 0;
    while (q_out.size() != 3 && n < 50) begin step(); n++; end
    if (n >= 50) timeout("wait_outst3");
    force_rd = 1;
    force_pc = 16'h0100;
    step();
    dlog.delete();
    repeat (15) step();
    chk("redirect_first_pc", dlog[0].pc, 16'h0100);
    chk("redirect_first_word", dlog[0].w, mem_word(16'h0100));
    chk("redirect_next_pc", dlog[1].pc, 16'h0101);
    // PC wrap
    lat_lo = 1;
    lat_hi = 1;
    repeat (10) step();
    force_rd = 1;
    force_pc = 16'hFFFF;
    step();
    step();
    chk("wrap_req_a", s_req, 1);
    chk("wrap_addr_a", s_addr, 16'hFFFF);
    step();
    chk("wrap_req_b", s_req, 1);
    chk("wrap_addr_b", s_addr, 16'h0000);
    // Reset with two reads outstanding; their responses return after release
    lat_lo = 3;
    lat_hi = 3;
    n = 0;
    while (q_out.size() != 2 && n < 50) begin step(); n++; end
    if (n >= 50) timeout("wait_outst2");
    want_reset = 1;
    gmode = 0;
    step();
    want_reset = 0;
    n = 0;
    while (mem_q.size() != 0 && n < 20) begin step(); n++; end
    if (n >= 20) timeout("wait_mem_idle");
    gmode = 1;
    dlog.delete();
    step();
    chk("restart_req", s_req, 1);
    chk("restart_addr", s_addr, RESET_PC);
    repeat (8) step();
    chk("restart_first_pc", dlog[0].pc, RESET_PC);
    chk("restart_first_word", dlog[0].w, 16'h0050);
    // Randomized traffic
    gmode = 2;
    rmode = 2;
    lat_lo = 1;
    lat_hi = 4;
    rd_pct = 4;
    repeat (3000) step();
`ifdef FETCH_STALL_CNT_EN
    rd_pct = 0;
    gmode = 0;
    rmode = 1;
    want_reset = 1;
    step();
    want_reset = 0;
    repeat (8) step();
    chk("stall_7", s_stall, 16'd7);
    gmode = 1;
    repeat (4) step();
    chk("stall_fill", s_stall, 16'd10);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
